sampa_pon_axil_regs: RTL and testbench
======================================

Name: sampa_pon_axil_regs

Overview:
AXI4-Lite slave (responder) register file for the SAMPA_PON IP; the S00_AXI-side counterpart of the VIP master that drives AXI4LITE_WRITE_BURST/READ_BURST. Holds NUM_REGS 32-bit read/write control registers, exposes them to fabric logic, and issues a one-cycle write pulse per register. Sits between the AXI interconnect and SAMPA power-on/control logic.

Parameters:
NUM_REGS, 4, number of implemented 32-bit registers (1..2^(ADDR_WIDTH-2))
ADDR_WIDTH, 4, byte-address width of AWADDR/ARADDR
DATA_WIDTH, 32, data width (fixed 32; WSTRB is DATA_WIDTH/8)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_o  out  NUM_REGS*DATA_WIDTH  register contents, reg n at [n*32 +: 32]
reg_wr_o  out  NUM_REGS  one-cycle pulse when reg n written

Behaviour:
- Reset (ARESETN low, async): all registers 0, reg_wr_o 0, BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0, AWREADY/WREADY/ARREADY 0 while asserted; readies go 1 the first cycle after release.
- Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Write path: AW and W channels independent. AWREADY=1 while no AW held; on AWVALID&AWREADY latch address, drop AWREADY. Same for W (data+strobe). Either order, same cycle, or any gap allowed.
- Commit: in the cycle both AW and W are held and (BVALID=0 or BREADY=1): update strobed bytes of target register, pulse reg_wr_o[idx] next cycle, set BVALID=1 BRESP=OKAY, clear both holds (readies return high next cycle). Write latency: BVALID 1 cycle after the later of AW/W handshake.
- BVALID held until BREADY; no second commit while BVALID=1 and BREADY=0 (back-pressure stalls AW/W acceptance once holds are full).
- WSTRB=0: no register change, reg_wr_o still pulses, OKAY response.
- Read path: ARREADY = ~RVALID. On AR handshake, RDATA registered with register value, RVALID=1 next cycle, RRESP=OKAY. RDATA/RVALID stable until RREADY. Back-to-back reads at 1 per 2 cycles minimum.
- Simultaneous read handshake and write commit to same register: read returns pre-write value.
- Index >= NUM_REGS: write ignored (no pulse), read returns 0, response per Optional Feature.
- Reset mid-transaction: all holds and pending responses dropped; no response issued for aborted transfers.

Optional Feature:
SAMPA_PON_AXIL_DECERR_EN
- Defined: accesses to index >= NUM_REGS return BRESP/RRESP = SLVERR (2'b10); data behaviour unchanged.
- Undefined: such accesses return OKAY (2'b00).

Test Plan:
- Reset, write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> RDATA 0x1..0x4, all RRESP OKAY, reg_o = 0x00000004_00000003_00000002_00000001, one reg_wr_o pulse per write.
- AWVALID to 0x8 three cycles before WVALID 0xDEADBEEF -> AWREADY low after handshake, BVALID exactly 1 cycle after W handshake, reg 2 = 0xDEADBEEF.
- Reg1=0x11223344, write 0xAABBCCDD WSTRB=4'b0010 -> reg1=0x1122CC44.
- BREADY low 5 cycles after write; second AW/W offered -> second write not committed, BVALID held, commit occurs cycle BREADY rises; both responses observed in order.
- ADDR_WIDTH=5, NUM_REGS=4: write 0x55 to 0x10, read 0x10 -> RDATA 0, no reg_wr_o, resp OKAY (SLVERR with SAMPA_PON_AXIL_DECERR_EN).
- Assert ARESETN low with AW held and RVALID pending -> outputs zero immediately; after release readies high, regs 0, no stale BVALID/RVALID.

Source files
------------

// File: rtl/sampa_pon_axil_regs.sv
// rtl/sampa_pon_axil_regs.sv - AXI4-Lite register file for SAMPA_PON; define SAMPA_PON_AXIL_DECERR_EN for SLVERR on unmapped indices
module sampa_pon_axil_regs #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SAMPA_PON_AXIL_DECERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    logic                  ready_en;
    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_wr_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  aw_mapped;
    logic                  ar_mapped;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_inputs;

    // Protection bits and byte offsets carry no meaning for this block
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies stay low through reset and rise once the block is out of reset
    assign S_AXI_AWREADY = ready_en & ~aw_held;
    assign S_AXI_WREADY  = ready_en & ~w_held;
    assign S_AXI_ARREADY = ready_en & ~rvalid_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // A pending unaccepted response blocks the next commit
    assign commit = aw_held & w_held & (~bvalid_q | S_AXI_BREADY);

    assign ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign aw_mapped = 32'(aw_idx_q) < NUM_REGS_U;
    assign ar_mapped = 32'(ar_idx) < NUM_REGS_U;

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign reg_wr_o     = reg_wr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    // Read mux; unmapped indices read as zero
    always_comb begin
        rd_val = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (ar_idx == IDX_W'(n)) begin
                rd_val = regs[n];
            end
        end
    end

    // Ready enable: first clock after reset release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Address and data holds, filled independently and emptied together on commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    // Register storage with byte strobes and a one-cycle write pulse per commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                regs[n] <= '0;
            end
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= '0;
            if (commit) begin
                for (int n = 0; n < NUM_REGS; n++) begin
                    if (aw_idx_q == IDX_W'(n)) begin
                        reg_wr_q[n] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                regs[n][b*8 +: 8] <= wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Write response channel
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_mapped ? RESP_OKAY : RESP_UNMAPPED;
        end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read data channel; captures the value present before any same-edge commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_mapped ? RESP_OKAY : RESP_UNMAPPED;
            rdata_q  <= rd_val;
        end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sampa_pon_axil_regs.sv
// tb/tb_sampa_pon_axil_regs.sv - self-checking bench for sampa_pon_axil_regs
module tb_sampa_pon_axil_regs;
    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [1:0] OK = 2'b00;
`ifdef SAMPA_PON_AXIL_DECERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] reg_o;
    logic [NR-1:0] reg_wr;

    always #5 clk = ~clk;

    sampa_pon_axil_regs #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_o(reg_o), .reg_wr_o(reg_wr)
    );

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[17];
    int errors = 0;
    int checks = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [1:0]  b_cur;
    logic [33:0] r_cur;
    int pulse_cnt[NR];
    int exp_pulse[NR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response scoreboard and write-pulse counter
    always @(negedge clk) begin
        if (rst_n) begin
            for (int n = 0; n < NR; n++) if (reg_wr[n]) pulse_cnt[n]++;
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_bresp: got bvalid=1 resp=%0h expected no response", bresp);
                end else begin
                    b_cur = bq.pop_front();
                    check("bresp", 128'(bresp), 128'(b_cur));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_rresp: got rvalid=1 data=%0h expected no response", rdata);
                end else begin
                    r_cur = rq.pop_front();
                    check("rdata", 128'(rdata), 128'(r_cur[31:0]));
                    check("rresp", 128'(rresp), 128'(r_cur[33:32]));
                end
            end
        end
    end

    task automatic drive_wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs;
        bq.push_back(resp);
        if (int'(addr[AW-1:2]) < NR) exp_pulse[int'(addr[AW-1:2])]++;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1; end
        end
        if (!(aw_done && w_done)) begin
            errors++; checks++;
            $display("FAIL wr_handshake_timeout: got aw=%0d w=%0d expected both accepted", aw_done, w_done);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        for (int c = 0; c < 40 && (bq.size() != 0 || rq.size() != 0); c++) begin
            @(posedge clk); #1;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got %0d/%0d outstanding expected 0", name, bq.size(), rq.size());
            bq.delete(); rq.delete();
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp_data, input logic [1:0] resp);
        bit done = 0;
        bit hs;
        rq.push_back({resp, exp_data});
        araddr = addr; arvalid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL rd_handshake_timeout: got no arready expected accept");
            arvalid = 1'b0;
        end
        wait_empty("rd");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'h00, 32'h00000001, 4'hF, 32'h0, OK};
        vecs[1]  = '{1'b1, 5'h04, 32'h00000002, 4'hF, 32'h0, OK};
        vecs[2]  = '{1'b1, 5'h08, 32'h00000003, 4'hF, 32'h0, OK};
        vecs[3]  = '{1'b1, 5'h0C, 32'h00000004, 4'hF, 32'h0, OK};
        vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h00000001, OK};
        vecs[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h00000002, OK};
        vecs[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h00000003, OK};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h00000004, OK};
        vecs[8]  = '{1'b1, 5'h04, 32'h11223344, 4'hF, 32'h0, OK};
        vecs[9]  = '{1'b1, 5'h04, 32'hAABBCCDD, 4'b0010, 32'h0, OK};
        vecs[10] = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h1122CC44, OK};
        vecs[11] = '{1'b1, 5'h10, 32'h00000055, 4'hF, 32'h0, OOR};
        vecs[12] = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h00000000, OOR};
        vecs[13] = '{1'b1, 5'h0C, 32'hFFFFFFFF, 4'h0, 32'h0, OK};
        vecs[14] = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h00000004, OK};
        vecs[15] = '{1'b1, 5'h01, 32'h00000077, 4'hF, 32'h0, OK};
        vecs[16] = '{1'b0, 5'h02, 32'h0, 4'h0, 32'h00000077, OK};

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'b0; arprot = 3'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readies", 128'({awready, wready, arready}), 128'(3'b000));
        check("rst_valids", 128'({bvalid, rvalid, bresp, rresp}), 128'(6'b0));
        check("rst_rdata", 128'(rdata), 128'(0));
        check("rst_regs", reg_o, 128'(0));
        check("rst_wr", 128'(reg_wr), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_readies", 128'({awready, wready, arready}), 128'(3'b111));

        // Table-driven writes/reads
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                drive_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
                wait_empty("wr");
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end
            if (i == 7) begin
                check("reg_o_1234", reg_o, 128'h00000004_00000003_00000002_00000001);
                for (int n = 0; n < NR; n++) check("pulse_first4", 128'(pulse_cnt[n]), 128'(exp_pulse[n]));
            end
        end
        for (int n = 0; n < NR; n++) check("pulse_table", 128'(pulse_cnt[n]), 128'(exp_pulse[n]));

        // AW three cycles ahead of W
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk); check("early_awready", 128'(awready), 128'(1));
        @(posedge clk); #1 awvalid = 1'b0;
        repeat (3) begin
            @(negedge clk); check("aw_held_ready_low", 128'(awready), 128'(0));
        end
        @(posedge clk); #1;
        bq.push_back(OK); exp_pulse[2]++;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); check("late_wready", 128'(wready), 128'(1));
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk); check("bvalid_not_yet", 128'(bvalid), 128'(0));
        @(negedge clk); check("bvalid_one_cycle", 128'(bvalid), 128'(1));
        wait_empty("early_aw");
        check("reg2_deadbeef", 128'(reg_o[95:64]), 128'(32'hDEADBEEF));

        // BREADY back-pressure with a second write queued
        bready = 1'b0;
        drive_wr(5'h00, 32'hA0A0A0A0, 4'hF, OK);
        drive_wr(5'h04, 32'hB1B1B1B1, 4'hF, OK);
        repeat (5) begin
            @(negedge clk);
            check("bp_bvalid", 128'(bvalid), 128'(1));
            check("bp_awready", 128'(awready), 128'(0));
            check("bp_reg1_old", 128'(reg_o[63:32]), 128'(32'h1122CC44));
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1;
        check("bp_commit_reg1", 128'(reg_o[63:32]), 128'(32'hB1B1B1B1));
        check("bp_second_bvalid", 128'(bvalid), 128'(1));
        wait_empty("bp");

        // Read handshake on the same edge as a commit to the same register
        bq.push_back(OK); exp_pulse[3]++;
        rq.push_back({OK, 32'h00000004});
        awaddr = 5'h0C; wdata = 32'h33333333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk); check("simul_ready", 128'({awready, wready, arready}), 128'(3'b111));
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; araddr = 5'h0C; arvalid = 1'b1;
        @(negedge clk); check("simul_arready", 128'(arready), 128'(1));
        @(posedge clk); #1 arvalid = 1'b0;
        wait_empty("simul");
        do_read(5'h0C, 32'h33333333, OK);
        check("reg_o_final", reg_o, 128'h33333333_DEADBEEF_B1B1B1B1_A0A0A0A0);
        for (int n = 0; n < NR; n++) check("pulse_total", 128'(pulse_cnt[n]), 128'(exp_pulse[n]));

        // Reset with AW held and a read response pending
        rready = 1'b0; araddr = 5'h00; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0; awaddr = 5'h04; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        check("pre_rst_rvalid", 128'(rvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 128'({awready, wready, arready, bvalid, rvalid}), 128'(5'b0));
        check("mid_rst_rdata", 128'(rdata), 128'(0));
        check("mid_rst_regs", reg_o, 128'(0));
        bq.delete(); rq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        check("rel_readies", 128'({awready, wready, arready}), 128'(3'b111));
        check("rel_no_stale", 128'({bvalid, rvalid}), 128'(2'b00));
        check("rel_regs", reg_o, 128'(0));
        wdata = 32'h00000099; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (4) begin
            @(negedge clk); check("no_stale_aw_commit", 128'({bvalid, reg_wr}), 128'(0));
        end
        @(posedge clk); #1;
        bq.push_back(OK);
        awaddr = 5'h04; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        wait_empty("post_rst_wr");
        check("post_rst_reg1", 128'(reg_o[63:32]), 128'(32'h00000099));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
